picos_finish_task_sender: RTL



---
 rtl/picos_pkg.sv | 10 +
 rtl/picos_finish_task_fifo.sv | 77 +++++++
 rtl/picos_finish_task_sender.sv | 89 ++++++++
 3 files changed

// File: rtl/picos_pkg.sv
// Shared types and constants for the Picos finish-task path.
package picos_pkg;

  localparam int PICOS_FINISH_DATA_WIDTH = 32;
  localparam int STALL_CNT_WIDTH         = 16;

  typedef logic [PICOS_FINISH_DATA_WIDTH-1:0] picos_task_id_t;
  typedef logic [STALL_CNT_WIDTH-1:0]         stall_cnt_t;

endpackage

// File: rtl/picos_finish_task_fifo.sv
// Register-array FIFO with occupancy count; full/empty derive from the count.
module picos_finish_task_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;
  logic [ADDR_W-1:0] w_head_idx;

  assign full      = (r_count == PTR_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign count     = r_count;

  // When empty, point one slot behind the head so the last popped word stays visible.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_head_idx = r_rd_ptr[ADDR_W-1:0];
    if (empty) begin
      w_head_idx = r_rd_ptr[ADDR_W-1:0] - ADDR_W'(1);
    end
  end

  assign rdata = r_mem[w_head_idx];

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is reset too, so tdata reads zero out of reset and no stale word survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/picos_finish_task_sender.sv
// Finish-task transmitter: buffers finish notifications and streams them to Picos over AXIS.
module picos_finish_task_sender
  import picos_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   finish_valid,
  output logic                   finish_ready,
  input  picos_task_id_t         finish_picos_id,
  output logic                   M00_AXIS_tvalid,
  input  logic                   M00_AXIS_tready,
  output picos_task_id_t         M00_AXIS_tdata,
  output logic [$clog2(DEPTH):0] pending_count,
  output logic [31:0]            sent_count,
  output logic                   stall_alarm
);

  localparam int         DATA_WIDTH    = PICOS_FINISH_DATA_WIDTH;
  localparam stall_cnt_t STALL_LIMIT_C = stall_cnt_t'(STALL_LIMIT);

  logic        r_out_of_reset;
  logic [31:0] r_sent_count;
  stall_cnt_t  r_stall_cnt;
  stall_cnt_t  w_stall_next;
  logic        r_stall_alarm;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  picos_finish_task_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .wdata (finish_picos_id),
    .pop   (w_pop),
    .rdata (M00_AXIS_tdata),
    .count (pending_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Ready depends only on registered state, never on tready.
  assign finish_ready    = !w_full && r_out_of_reset;
  assign w_push          = finish_valid && finish_ready;
  assign M00_AXIS_tvalid = !w_empty;
  assign w_pop           = M00_AXIS_tvalid && M00_AXIS_tready;
  assign sent_count      = r_sent_count;
  assign stall_alarm     = r_stall_alarm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_of_reset <= 1'b0;
      r_sent_count   <= '0;
    end else begin
      r_out_of_reset <= 1'b1;
      if (w_pop) begin
        r_sent_count <= r_sent_count + 32'd1;
      end
    end
  end

  // Count consecutive back-pressured cycles; any pop or idle cycle restarts the count.
  always_comb begin
    w_stall_next = r_stall_cnt;
    if (w_pop || !M00_AXIS_tvalid) begin
      w_stall_next = '0;
    end else if (r_stall_cnt != '1) begin
      w_stall_next = r_stall_cnt + stall_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt   <= '0;
      r_stall_alarm <= 1'b0;
    end else begin
      r_stall_cnt   <= w_stall_next;
      r_stall_alarm <= (w_stall_next >= STALL_LIMIT_C);
    end
  end

endmodule
